// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and access sequencer for a byte-addressable data memory.
//
// The memory samples its controls on the negedge and registers its read data (rd). Each
// accepted request gets one ISSUE cycle on the memory and then one tagged response. Requests
// that are misaligned, out of range or of an illegal size are answered with rsp_err and never
// reach the memory.
//
// Ports:
//   clk, rst                 clock (logic on posedge), synchronous active-high reset
//   reqN_valid/ready         request handshake for requester N (0: fetch/debug, 1: LSU)
//   reqN_we/size/unsigned    store flag, size (00 byte, 01 half, 10 word), load zero-extend
//   reqN_addr/wdata          byte address and right-justified store data
//   rsp_valid/ready          response handshake; rsp_id/err/rdata held while valid & !ready
//   mem_gwe, mem_bw0..3      word write enable and per-lane byte write strobes
//   mem_rd                   registered read request
//   mem_addr/wdata/rdata     memory address, store data and read data
module mem_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned MEM_LEN = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_we,
    input  logic [1:0]      req0_size,
    input  logic            req0_unsigned,
    input  logic [XLEN-1:0] req0_addr,
    input  logic [XLEN-1:0] req0_wdata,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_we,
    input  logic [1:0]      req1_size,
    input  logic            req1_unsigned,
    input  logic [XLEN-1:0] req1_addr,
    input  logic [XLEN-1:0] req1_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic            rsp_id,
    output logic            rsp_err,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            mem_gwe,
    output logic            mem_rd,
    output logic            mem_bw0,
    output logic            mem_bw1,
    output logic            mem_bw2,
    output logic            mem_bw3,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e          state_q, state_d;
    logic            ptr_q, ptr_d;
    logic            id_q, we_q, uns_q, err_q;
    logic [1:0]      size_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;

    logic            gnt;
    logic            latch_en;
    logic            sel_we, sel_uns, sel_misaligned, sel_illegal;
    logic [1:0]      sel_size;
    logic [XLEN-1:0] sel_addr, sel_wdata;

    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [XLEN-1:0] load_ext;
    logic [3:0]      lane_mask;
    logic [3:0]      bw_strobe;

    // Pointer port wins a tie; otherwise whichever port is valid.
    always_comb begin
        if (req0_valid && req1_valid) begin
            gnt = ptr_q;
        end else begin
            gnt = req1_valid;
        end
    end

    assign sel_we    = gnt ? req1_we       : req0_we;
    assign sel_uns   = gnt ? req1_unsigned : req0_unsigned;
    assign sel_size  = gnt ? req1_size     : req0_size;
    assign sel_addr  = gnt ? req1_addr     : req0_addr;
    assign sel_wdata = gnt ? req1_wdata    : req0_wdata;

    always_comb begin
        sel_misaligned = 1'b0;
        case (sel_size)
            2'b01:   sel_misaligned = sel_addr[0];
            2'b10:   sel_misaligned = |sel_addr[1:0];
            default: sel_misaligned = 1'b0;
        endcase
        sel_illegal = (sel_size == 2'b11) || sel_misaligned ||
                      ((sel_addr >> 2) >= XLEN'(MEM_LEN));
    end

    // Load extraction from the word the memory registered during ISSUE.
    assign lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_ext = '0;
        case (size_q)
            2'b00:   load_ext = {{(XLEN-8){~uns_q & lane_byte[7]}}, lane_byte};
            2'b01:   load_ext = {{(XLEN-16){~uns_q & lane_half[15]}}, lane_half};
            default: load_ext = mem_rdata;
        endcase
        if (we_q) begin
            load_ext = '0;
        end
    end

    always_comb begin
        lane_mask = 4'b0000;
        case (size_q)
            2'b00:   lane_mask = 4'b0001 << addr_q[1:0];
            2'b01:   lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b0000;
        endcase
    end

    // Outputs are forced quiet while rst is high so an aborted store never strobes memory.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        latch_en   = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_err    = 1'b0;
        rsp_rdata  = '0;
        mem_gwe    = 1'b0;
        mem_rd     = 1'b0;
        bw_strobe  = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    req0_ready = req0_valid && !gnt;
                    req1_ready = req1_valid && gnt;
                    if (req0_valid || req1_valid) begin
                        latch_en = 1'b1;
                        ptr_d    = ~gnt;
                        state_d  = sel_illegal ? StResp : StIssue;
                    end
                end
                StIssue: begin
                    mem_addr  = addr_q;
                    mem_wdata = wdata_q;
                    if (!we_q) begin
                        mem_rd = 1'b1;
                    end else if (size_q == 2'b10) begin
                        mem_gwe = 1'b1;
                    end else begin
                        bw_strobe = lane_mask;
                    end
                    state_d = StResp;
                end
                StResp: begin
                    rsp_valid = 1'b1;
                    rsp_id    = id_q;
                    rsp_err   = err_q;
                    rsp_rdata = rdata_q;
                    if (rsp_ready) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign {mem_bw3, mem_bw2, mem_bw1, mem_bw0} = bw_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (latch_en) begin
                id_q    <= gnt;
                we_q    <= sel_we;
                uns_q   <= sel_uns;
                err_q   <= sel_illegal;
                size_q  <= sel_size;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                rdata_q <= '0;
            end else if (state_q == StIssue) begin
                rdata_q <= load_ext;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a negedge byte-lane memory model.
module tb_mem_arbiter;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MEM_LEN = 256;
    localparam int unsigned NBYTES  = MEM_LEN * 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0, req0_unsigned = 1'b0;
    logic [1:0]  req0_size = 2'b00;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0, req1_unsigned = 1'b0;
    logic [1:0]  req1_size = 2'b00;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_err;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        mem_gwe, mem_rd, mem_bw0, mem_bw1, mem_bw2, mem_bw3;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  dut_bw;

    assign dut_bw = {mem_bw3, mem_bw2, mem_bw1, mem_bw0};

    mem_arbiter #(.XLEN(XLEN), .MEM_LEN(MEM_LEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_size(req0_size), .req0_unsigned(req0_unsigned), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_size(req1_size), .req1_unsigned(req1_unsigned), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata),
        .mem_gwe(mem_gwe), .mem_rd(mem_rd), .mem_bw0(mem_bw0), .mem_bw1(mem_bw1),
        .mem_bw2(mem_bw2), .mem_bw3(mem_bw3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;  // 0: always ready, 1: random, 2: stalled

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    function automatic logic [31:0] init_word(input int w);
        return 32'(w) * 32'h9E37_79B1 ^ 32'hC0FF_EE11;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void chk_quiet(input string name);
        logic [106:0] v;
        v = {req0_ready, req1_ready, rsp_valid, rsp_id, rsp_err, rsp_rdata, mem_gwe, mem_rd,
             dut_bw, mem_addr, mem_wdata};
        checks++;
        if (v !== '0) begin
            errors++;
            $display("FAIL %s: outputs 0x%0h, required all zero", name, v);
        end
    endfunction

    // Memory: writes/reads on negedge. Strobed lanes take successive bytes of the
    // right-justified store data, lowest strobed lane first.
    logic [31:0] mem [MEM_LEN];
    initial begin : mem_model
        logic [31:0] w;
        int j;
        for (int i = 0; i < int'(MEM_LEN); i++) mem[i] = init_word(i);
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_gwe === 1'b1) begin
                mem[mem_addr[9:2]] = mem_wdata;
            end else if (|dut_bw) begin
                w = mem[mem_addr[9:2]];
                j = 0;
                for (int k = 0; k < 4; k++) begin
                    if (dut_bw[k]) begin
                        w[8*k +: 8] = mem_wdata[8*j +: 8];
                        j++;
                    end
                end
                mem[mem_addr[9:2]] = w;
            end
            if (mem_rd === 1'b1) mem_rdata = mem[mem_addr[9:2]];
        end
    end

    // Reference model state: byte-array memory, expected responses and memory operations.
    typedef struct {
        bit          id;
        bit          err;
        logic [31:0] rdata;
        int          cyc;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        bit          we;
        int          nb;
        logic [31:0] wdata;
    } mop_t;

    logic [7:0] refm [NBYTES];
    rsp_t exp_q[$];
    mop_t mq[$];
    bit   grant_log[$];
    bit   busy = 1'b0;
    bit   ptr = 1'b0;
    bit   held = 1'b0;
    int   rsp_cnt = 0;
    logic        last_id, last_err, h_id, h_err;
    logic [31:0] last_rdata, h_rdata;

    function automatic void model_accept(input bit id, input bit we, input logic [1:0] sz,
                                         input bit uns, input logic [31:0] a,
                                         input logic [31:0] wd);
        int nb;
        bit err;
        logic [31:0] v;
        rsp_t r;
        mop_t m;
        nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        err = (sz == 2'b11) || ((a % nb) != 0) || ((a >> 2) >= MEM_LEN);
        v = '0;
        if (!err && !we) begin
            for (int i = 0; i < nb; i++) v = v | (32'(refm[a + i]) << (8 * i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 1);
        end
        r.id = id; r.err = err; r.rdata = v; r.cyc = cyc;
        exp_q.push_back(r);
        if (!err) begin
            m.addr = a; m.we = we; m.nb = nb; m.wdata = wd;
            mq.push_back(m);
        end
    endfunction

    initial begin : monitor
        bit v0, v1, e0, e1, g;
        mop_t m;
        rsp_t r;
        logic [5:0] exp_ctl;
        for (int i = 0; i < int'(NBYTES); i++) refm[i] = init_word(i / 4)[8*(i%4) +: 8];
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                chk_quiet("reset_outputs");
                exp_q.delete(); mq.delete(); grant_log.delete();
                busy = 1'b0; ptr = 1'b0; held = 1'b0;
            end else begin
                // Arbitration and acceptance
                v0 = (req0_valid === 1'b1);
                v1 = (req1_valid === 1'b1);
                if (busy) begin
                    e0 = 1'b0; e1 = 1'b0; g = 1'b0;
                end else begin
                    g  = (v0 && v1) ? ptr : v1;
                    e0 = v0 && !g;
                    e1 = v1 && g;
                end
                chk("req_ready", {30'b0, req1_ready, req0_ready}, {30'b0, e1, e0});
                if (e0 || e1) begin
                    grant_log.push_back(g);
                    if (g) model_accept(1'b1, req1_we, req1_size, req1_unsigned, req1_addr,
                                        req1_wdata);
                    else   model_accept(1'b0, req0_we, req0_size, req0_unsigned, req0_addr,
                                        req0_wdata);
                    busy = 1'b1;
                    ptr  = !g;
                end
                // Memory activity
                if (mem_gwe !== 1'b0 || mem_rd !== 1'b0 || dut_bw !== 4'b0) begin
                    if (mq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_mem: gwe=%b rd=%b bw=%b, required no access",
                                 mem_gwe, mem_rd, dut_bw);
                    end else begin
                        m = mq.pop_front();
                        exp_ctl = {m.we && m.nb == 4, !m.we,
                                   (m.we && m.nb < 4) ? 4'(((1 << m.nb) - 1) << m.addr[1:0])
                                                      : 4'b0};
                        chk("mem_ctl", {26'b0, mem_gwe, mem_rd, dut_bw}, {26'b0, exp_ctl});
                        chk("mem_addr", mem_addr, m.addr);
                        chk("mem_wdata", mem_wdata, m.wdata);
                        if (m.we)
                            for (int i = 0; i < m.nb; i++) refm[m.addr + i] = m.wdata[8*i +: 8];
                    end
                end
                // Responses
                if (rsp_valid === 1'b1) begin
                    if (!held) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL rsp_unexpected: id=%b rdata=0x%08h, required none",
                                     rsp_id, rsp_rdata);
                        end else begin
                            r = exp_q.pop_front();
                            chk("rsp_id", {31'b0, rsp_id}, {31'b0, r.id});
                            chk("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
                            chk("rsp_rdata", rsp_rdata, r.rdata);
                            chk("rsp_latency", cyc - r.cyc, r.err ? 1 : 2);
                        end
                        h_id = rsp_id; h_err = rsp_err; h_rdata = rsp_rdata;
                        last_id = rsp_id; last_err = rsp_err; last_rdata = rsp_rdata;
                    end else begin
                        chk("rsp_stable_tag", {30'b0, rsp_id, rsp_err}, {30'b0, h_id, h_err});
                        chk("rsp_stable_rdata", rsp_rdata, h_rdata);
                    end
                    held = (rsp_ready !== 1'b1);
                    if (rsp_ready === 1'b1) begin
                        busy = 1'b0;
                        rsp_cnt++;
                    end
                end else if (held) begin
                    checks++; errors++;
                    $display("FAIL rsp_dropped: rsp_valid=0 before handshake, required 1");
                    held = 1'b0;
                end
            end
        end
    end

    // Presents a request on port p from posedge+1 and holds it until accepted.
    task automatic drive(input bit p, input bit we, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        if (p) begin
            req1_we = we; req1_size = sz; req1_unsigned = uns; req1_addr = a;
            req1_wdata = wd; req1_valid = 1'b1;
        end else begin
            req0_we = we; req0_size = sz; req0_unsigned = uns; req0_addr = a;
            req0_wdata = wd; req0_valid = 1'b1;
        end
        while (!done) begin
            @(negedge clk);
            if ((p ? req1_ready : req0_ready) === 1'b1) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 300) begin
                    checks++; errors++;
                    $display("FAIL accept_timeout: port %0d no ready in %0d cycles, required 300",
                             p, n);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_cnt < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (rsp_cnt < target) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_cnt, target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xfer(input bit p, input bit we, input logic [1:0] sz, input bit uns,
                        input logic [31:0] a, input logic [31:0] wd);
        int target;
        target = rsp_cnt + 1;
        drive(p, we, sz, uns, a, wd);
        wait_rsp(target);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int base, n, bad;
        logic [31:0] init_w8;
        logic [1:0] sz;
        logic [31:0] a;
        init_w8 = init_word(8);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Word store then load
        xfer(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        chk("st_word_rdata", last_rdata, 32'h0);
        xfer(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("ld_word_id", {31'b0, last_id}, 32'h0);
        chk("ld_word_err", {31'b0, last_err}, 32'h0);
        chk("ld_word_rdata", last_rdata, 32'hDEAD_BEEF);

        // Byte stores and signed/unsigned loads at lane 3
        xfer(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_007F);
        xfer(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("ld_byte_pos", last_rdata, 32'h0000_007F);
        xfer(1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h1234_5680);
        xfer(1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        chk("ld_byte_neg", last_rdata, 32'hFFFF_FF80);
        xfer(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        chk("ld_byte_uns", last_rdata, 32'h0000_0080);

        // Half store in the upper lanes
        xfer(1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000_A55A);
        xfer(1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        chk("ld_half_neg", last_rdata, 32'hFFFF_A55A);
        xfer(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        chk("half_low_lanes", {16'b0, last_rdata[15:0]}, {16'b0, init_w8[15:0]});

        // Error cases
        xfer(1'b0, 1'b1, 2'b10, 1'b0, 32'h02, 32'h1111_1111);
        chk("err_word_mis", {31'b0, last_err}, 32'h1);
        xfer(1'b1, 1'b0, 2'b01, 1'b0, 32'h05, 32'h0);
        chk("err_half_mis", {31'b0, last_err}, 32'h1);
        xfer(1'b0, 1'b1, 2'b11, 1'b0, 32'h30, 32'h2222_2222);
        chk("err_size", {31'b0, last_err}, 32'h1);
        xfer(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h3333_3333);
        chk("err_range", {31'b0, last_err}, 32'h1);
        chk("err_range_rdata", last_rdata, 32'h0);

        // Response stall with another request pending
        rdy_mode = 2;
        @(posedge clk);
        #1;
        base = rsp_cnt;
        fork
            drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
            drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
            begin
                n = 0;
                while (rsp_valid !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) @(negedge clk);
                chk("stall_rsp_valid", {31'b0, rsp_valid}, 32'h1);
                chk("stall_ready0", {31'b0, req0_ready}, 32'h0);
                chk("stall_ready1", {31'b0, req1_ready}, 32'h0);
                rdy_mode = 0;
            end
        join
        wait_rsp(base + 2);

        // Reset during the ISSUE cycle of a store
        drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h1234_5678);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_reset_outputs");
        chk("rst_abort_no_write", mem[16], init_word(16));
        @(posedge clk);
        #1;

        // Both ports continuously valid: grants alternate starting at port 0
        base = rsp_cnt;
        fork
            begin
                drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
                drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFE_F00D);
            end
            begin
                drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
                drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
            end
        join
        wait_rsp(base + 4);
        chk("grant_count", grant_log.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grant_log.size()) chk("grant_order", {31'b0, grant_log[i]}, i % 2);
        end

        // Random traffic from both ports with a random response consumer
        rdy_mode = 1;
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a  = ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 4095)
                                                 : $urandom_range(0, 127);
                drive(1'b0, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            end
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
                sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                a  = ($urandom_range(0, 9) == 0) ? $urandom_range(1024, 4095)
                                                 : $urandom_range(0, 127);
                drive(1'b1, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
            end
        join
        rdy_mode = 0;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_rsp_queue", exp_q.size(), 0);
        chk("drain_mem_queue", mq.size(), 0);

        bad = 0;
        for (int w = 0; w < int'(MEM_LEN); w++) begin
            if (mem[w] !== {refm[4*w+3], refm[4*w+2], refm[4*w+1], refm[4*w]}) bad++;
        end
        chk("mem_final_bad_words", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
